// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and elaboration-time helpers for the digit-serial
// adder/subtractor (addsub_serial_nbit).
//   state_t   : controller states S_IDLE / S_RUN / S_DONE
//   ndig()    : number of RUN cycles, WIDTH / DIGIT
//   cnt_w()   : digit counter width, $clog2(NDIG) but never below 1
//   width_ok(): legality of the WIDTH / DIGIT pair
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit width_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) &&
               ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// -----------------------------------------------------------------------------
// addsub_digit
// Combinational DIGIT-bit ripple slice of the serial adder/subtractor.
// For subtraction b_d is inverted here; the +1 comes in through cin.
// Ports:
//   a_d, b_d  : operand slices
//   cin       : carry into the slice LSB
//   sub       : 1 = invert b_d (subtract), 0 = add
//   s_d       : slice sum
//   cout      : carry out of the slice MSB
//   c_msb_in  : carry into the slice MSB (feeds signed-overflow detection)
// -----------------------------------------------------------------------------
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    input  logic             sub,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0]   c_s;
    logic [DIGIT-1:0] bx_s;

    // Ripple the carry through the slice, bit by bit.
    always_comb begin
        bx_s   = b_d ^ {DIGIT{sub}};
        c_s    = {(DIGIT+1){1'b0}};
        s_d    = {DIGIT{1'b0}};
        c_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i]   = a_d[i] ^ bx_s[i] ^ c_s[i];
            c_s[i+1] = (a_d[i] & bx_s[i]) | (c_s[i] & (a_d[i] ^ bx_s[i]));
        end
        cout     = c_s[DIGIT];
        c_msb_in = c_s[DIGIT-1];
    end

endmodule

// File: rtl/addsub_serial_nbit.sv
// -----------------------------------------------------------------------------
// addsub_serial_nbit
// Digit-serial WIDTH-bit unsigned adder/subtractor, DIGIT bits per clock,
// LSB first, with a start/done handshake. Results and flags are registered
// and held until the next completed operation.
// Optional feature macro: ADDSUB_SATURATE_EN -- clamp sum_diff on carry
// (all-ones) for add or borrow (all-zeros) for sub; flags stay raw.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, honoured only in IDLE or DONE
//   sel_add1_sub0     : 1 = a+b, 0 = a-b (latched with the operands)
//   a, b              : operands (latched on accepted start)
//   busy              : high while digits are being processed
//   done              : one-cycle pulse, result valid
//   sum_diff          : result
//   carry_borrow_out  : carry (add) or borrow (sub)
//   overflow          : two's-complement signed overflow
// -----------------------------------------------------------------------------
module addsub_serial_nbit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel_add1_sub0,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_diff,
    output logic             carry_borrow_out,
    output logic             overflow
);

    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int CNT_W = cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    if (!width_ok(WIDTH, DIGIT)) begin : g_param_check
        $error("addsub_serial_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               carry_r;
    logic               add_r;

    logic [DIGIT-1:0]       s_d_s;
    logic                   cout_s;
    logic                   c_msb_s;
    logic [WIDTH+DIGIT-1:0] res_wide_s;
    logic [WIDTH-1:0]       res_next_s;
    logic [WIDTH-1:0]       final_res_s;

    // Operand registers shift right each RUN cycle, so the active slice is
    // always the bottom DIGIT bits.
    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_r[DIGIT-1:0]),
        .b_d      (b_r[DIGIT-1:0]),
        .cin      (carry_r),
        .sub      (~add_r),
        .s_d      (s_d_s),
        .cout     (cout_s),
        .c_msb_in (c_msb_s)
    );

    // New slice enters at the top; after NDIG shifts the result is aligned.
    // The wide concatenation keeps the slice legal even when DIGIT == WIDTH.
    always_comb begin
        res_wide_s = {s_d_s, res_r};
        res_next_s = res_wide_s[WIDTH+DIGIT-1:DIGIT];
    end

    // Final result selection (optional clamp on unsigned out-of-range).
    always_comb begin
        final_res_s = res_next_s;
`ifdef ADDSUB_SATURATE_EN
        if (add_r && cout_s) begin
            final_res_s = {WIDTH{1'b1}};
        end else if (!add_r && !cout_s) begin
            final_res_s = {WIDTH{1'b0}};
        end else begin
            final_res_s = res_next_s;
        end
`endif
    end

    // Controller FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= S_IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            a_r              <= {WIDTH{1'b0}};
            b_r              <= {WIDTH{1'b0}};
            res_r            <= {WIDTH{1'b0}};
            carry_r          <= 1'b0;
            add_r            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            sum_diff         <= {WIDTH{1'b0}};
            carry_borrow_out <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        add_r   <= sel_add1_sub0;
                        carry_r <= ~sel_add1_sub0;   // +1 of a + ~b + 1
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= S_RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    res_r   <= res_next_s;
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        state_r          <= S_DONE;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        sum_diff         <= final_res_s;
                        carry_borrow_out <= add_r ? cout_s : ~cout_s;
                        overflow         <= c_msb_s ^ cout_s;
                    end else begin
                        state_r <= S_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial_nbit
// Self-checking bench for addsub_serial_nbit: WIDTH=8 with DIGIT=2 (main),
// DIGIT=1 and DIGIT=8 instances sharing the same stimulus.
// -----------------------------------------------------------------------------
module tb_addsub_serial_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       busy, done, cbo, ovf;
    logic [7:0] sum;
    logic       busy1, done1, cbo1, ovf1;
    logic [7:0] sum1;
    logic       busy8, done8, cbo8, ovf8;
    logic [7:0] sum8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_serial_nbit #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sel_add1_sub0(sel), .a(a), .b(b),
        .busy(busy), .done(done), .sum_diff(sum), .carry_borrow_out(cbo), .overflow(ovf));

    addsub_serial_nbit #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .sel_add1_sub0(sel), .a(a), .b(b),
        .busy(busy1), .done(done1), .sum_diff(sum1), .carry_borrow_out(cbo1), .overflow(ovf1));

    addsub_serial_nbit #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .sel_add1_sub0(sel), .a(a), .b(b),
        .busy(busy8), .done(done8), .sum_diff(sum8), .carry_borrow_out(cbo8), .overflow(ovf8));

    // Reference: {overflow, carry_borrow, result} from plain integer arithmetic.
    function automatic logic [9:0] ref_op(input logic s, input logic [7:0] x, input logic [7:0] y);
        int         full;
        logic [7:0] r;
        logic       cb;
        logic       ov;
        if (s) begin
            full = int'(x) + int'(y);
            r    = full[7:0];
            cb   = (full > 255);
            ov   = (x[7] == y[7]) && (r[7] != x[7]);
        end else begin
            full = int'(x) - int'(y);
            r    = full[7:0];
            cb   = (x < y);
            ov   = (x[7] != y[7]) && (r[7] != x[7]);
        end
`ifdef ADDSUB_SATURATE_EN
        if (cb) r = s ? 8'hFF : 8'h00;
`endif
        return {ov, cb, r};
    endfunction

    // Launch one operation from the current cycle and wait for done.
    task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int busy_cnt);
        sel = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cbo, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_main: got busy=%b done=%b sum=%h cb=%b ov=%b, want all 0",
                     busy, done, sum, cbo, ovf);
        end
        checks++;
        if ({busy1, done1, sum1, cbo1, ovf1, busy8, done8, sum8, cbo8, ovf8} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_variants: got d1 sum=%h d8 sum=%h busy/done nonzero or outputs nonzero, want all 0",
                     sum1, sum8);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [16:0] tbl [5];
        logic [9:0]  exp;
        int          lat, bc;
        tbl[0] = {1'b1, 8'h3C, 8'h25};
        tbl[1] = {1'b1, 8'hF0, 8'h20};
        tbl[2] = {1'b0, 8'h25, 8'h3C};
        tbl[3] = {1'b0, 8'h80, 8'h01};
        tbl[4] = {1'b1, 8'h7F, 8'h01};
        for (int i = 0; i < 5; i++) begin
            exp = ref_op(tbl[i][16], tbl[i][15:8], tbl[i][7:0]);
            run_op(tbl[i][16], tbl[i][15:8], tbl[i][7:0], lat, bc);
            checks++;
            if (lat != 4 || bc != 4) begin
                errors++;
                $display("FAIL directed%0d_latency: got lat=%0d busy_cycles=%0d, want 4/4", i, lat, bc);
            end
            checks++;
            if ({ovf, cbo, sum} !== exp) begin
                errors++;
                $display("FAIL directed%0d_result: got ov=%b cb=%b sum=%h, want ov=%b cb=%b sum=%h",
                         i, ovf, cbo, sum, exp[9], exp[8], exp[7:0]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || {ovf, cbo, sum} !== exp) begin
                errors++;
                $display("FAIL directed%0d_hold: got done=%b busy=%b sum=%h, want done=0 busy=0 sum=%h",
                         i, done, busy, sum, exp[7:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [9:0] exp;
        int         lat;
        exp = ref_op(1'b1, 8'h3C, 8'h25);
        sel = 1'b1; a = 8'h3C; b = 8'h25; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (lat == 1) begin
                start = 1'b1; sel = 1'b0; a = 8'h01; b = 8'hFE;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat != 4 || {ovf, cbo, sum} !== exp) begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d sum=%h cb=%b ov=%b, want lat=4 sum=%h cb=%b ov=%b",
                     lat, sum, cbo, ovf, exp[7:0], exp[8], exp[9]);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp1, exp2;
        int         lat, bc;
        exp1 = ref_op(1'b0, 8'h25, 8'h3C);
        exp2 = ref_op(1'b1, 8'h11, 8'h22);
        run_op(1'b0, 8'h25, 8'h3C, lat, bc);
        checks++;
        if (lat != 4 || {ovf, cbo, sum} !== exp1) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d sum=%h, want lat=4 sum=%h", lat, sum, exp1[7:0]);
        end
        run_op(1'b1, 8'h11, 8'h22, lat, bc);
        checks++;
        if (lat != 4 || bc != 4 || {ovf, cbo, sum} !== exp2) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d busy=%0d sum=%h, want lat=4 busy=4 sum=%h",
                     lat, bc, sum, exp2[7:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        sel = 1'b1; a = 8'h3C; b = 8'h25; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, sum, cbo, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cb=%b ov=%b, want all 0",
                     busy, done, sum, cbo, ovf);
        end
        seen = 0;
        repeat (10) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d busy/done cycles after abort, want 0", seen);
        end
    endtask

    task automatic test_digit_variants();
        logic [9:0] exp;
        logic [9:0] got, got1, got8;
        int         lat_m, lat_1, lat_8;
        exp = ref_op(1'b1, 8'h3C, 8'h25);
        lat_m = -1; lat_1 = -1; lat_8 = -1;
        got = 10'h000; got1 = 10'h000; got8 = 10'h000;
        sel = 1'b1; a = 8'h3C; b = 8'h25; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (done === 1'b1 && lat_m < 0)  begin lat_m = t; got  = {ovf, cbo, sum};    end
            if (done1 === 1'b1 && lat_1 < 0) begin lat_1 = t; got1 = {ovf1, cbo1, sum1}; end
            if (done8 === 1'b1 && lat_8 < 0) begin lat_8 = t; got8 = {ovf8, cbo8, sum8}; end
            @(posedge clk); #1;
        end
        checks++;
        if (lat_m != 4 || got !== exp) begin
            errors++;
            $display("FAIL digit2: got lat=%0d res=%h, want lat=4 res=%h", lat_m, got, exp);
        end
        checks++;
        if (lat_1 != 8 || got1 !== exp) begin
            errors++;
            $display("FAIL digit1: got lat=%0d res=%h, want lat=8 res=%h", lat_1, got1, exp);
        end
        checks++;
        if (lat_8 != 1 || got8 !== exp) begin
            errors++;
            $display("FAIL digit8: got lat=%0d res=%h, want lat=1 res=%h", lat_8, got8, exp);
        end
    endtask

    task automatic test_random();
        logic [9:0] prev, exp;
        logic       s, hold_ok, b2b;
        logic [7:0] x, y;
        int         lat;
        prev = ref_op(1'b1, 8'h3C, 8'h25);
        for (int n = 0; n < 1000; n++) begin
            s = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = 8'($urandom);
            b2b = 1'($urandom_range(0, 1));
            exp = ref_op(s, x, y);
            if (!b2b) begin
                @(posedge clk); #1;
            end
            sel = s; a = x; b = y; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat = 0; hold_ok = 1'b1;
            while (done !== 1'b1 && lat < 50) begin
                if ({ovf, cbo, sum} !== prev) hold_ok = 1'b0;
                a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom);
                start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                lat++;
            end
            start = 1'b0;
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d, want 4", n, lat);
            end
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("FAIL rand%0d_hold: outputs moved during RUN, want held at %h", n, prev);
            end
            checks++;
            if ({ovf, cbo, sum} !== exp) begin
                errors++;
                $display("FAIL rand%0d_result: sel=%b a=%h b=%h got ov=%b cb=%b sum=%h, want ov=%b cb=%b sum=%h",
                         n, s, x, y, ovf, cbo, sum, exp[9], exp[8], exp[7:0]);
            end
            prev = exp;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_variants();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
